fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, branch-target LUT and instruction fetch for the decoder
// Optional FETCH_REL_BR_EN: LUT entries are signed offsets added to pc instead of absolute targets.
module fetch_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8:0]        instrIn,
  input  logic              ctrlBranch,
  input  logic              isJump,
  input  logic              condFlag,
  input  logic              lutWe,
  input  logic [LUT_AW-1:0] lutWAddr,
  input  logic [PC_W-1:0]   lutWData,
  output logic [PC_W-1:0]   pc,
  output logic [8:0]        instr,
  output logic              valid,
  output logic              done,
  output logic [CNT_W-1:0]  cycleCount
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic              r_done;
  logic [PC_W-1:0]   r_lut [2**LUT_AW];

  logic [LUT_AW-1:0] w_idx;
  logic [PC_W-1:0]   w_lut_rd;
  logic [PC_W-1:0]   w_target;
  logic              w_halt;
  logic              w_taken;

  assign instr    = r_valid ? instrIn : 9'h000;
  assign w_halt   = instr[8] && (instr[2:0] == 3'b110);
  assign w_idx    = instr[4 +: LUT_AW];
  assign w_lut_rd = r_lut[w_idx];
  assign w_taken  = ctrlBranch && (isJump || condFlag);

`ifdef FETCH_REL_BR_EN
  // Entry and pc share a width, so the sign extension is implicit in the modular add.
  assign w_target = r_pc + w_lut_rd;
`else
  assign w_target = w_lut_rd;
`endif

  // Writes land at the edge, so a same-cycle read of the entry still sees the old target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**LUT_AW; i++) r_lut[i] <= '0;
    end else if (lutWe) begin
      r_lut[lutWAddr] <= lutWData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (w_halt) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_taken) begin
            r_pc <= w_target;
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end
        default: begin
          if (start) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
            r_done  <= 1'b0;
            r_pc    <= '0;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign pc         = r_pc;
  assign valid      = r_valid;
  assign done       = r_done;
  assign cycleCount = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed checks of fetch_unit against a behavioural model
module tb_fetch_unit;
  localparam int PC_W  = 10;
  localparam int DEPTH = 1024;
  localparam int CMAX  = 15;

  logic       clk, rst_n, start, condFlag, lutWe;
  logic [8:0] instrIn, instr;
  logic       ctrlBranch, isJump, valid, done;
  logic [3:0] lutWAddr, cycleCount;
  logic [9:0] lutWData, pc;

  logic [8:0] mem     [DEPTH];
  logic       br_mem  [DEPTH];
  logic       jmp_mem [DEPTH];

  // Instruction memory and decoder stand-ins, both combinational on pc.
  assign instrIn    = mem[pc];
  assign ctrlBranch = br_mem[pc];
  assign isJump     = jmp_mem[pc];

  fetch_unit #(.PC_W(PC_W), .LUT_AW(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instrIn(instrIn),
    .ctrlBranch(ctrlBranch), .isJump(isJump), .condFlag(condFlag),
    .lutWe(lutWe), .lutWAddr(lutWAddr), .lutWData(lutWData),
    .pc(pc), .instr(instr), .valid(valid), .done(done), .cycleCount(cycleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: running/done flags, pc, count and LUT contents as plain integers.
  bit m_run, m_done;
  int m_pc, m_cnt;
  int m_lut [16];

  function automatic bit is_halt(input logic [8:0] w);
    return w[8] && (w[2:0] == 3'b110);
  endfunction

  function automatic int next_pc(input int p);
    logic [8:0] w;
    int t;
    w = mem[p];
`ifdef FETCH_REL_BR_EN
    t = (p + m_lut[w[7:4]]) % DEPTH;
`else
    t = m_lut[w[7:4]];
`endif
    if (br_mem[p] && (jmp_mem[p] || condFlag)) return t;
    return (p + 1) % DEPTH;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_done <= 1'b0; m_pc <= 0; m_cnt <= 0;
      for (int i = 0; i < 16; i++) m_lut[i] <= 0;
    end else begin
      if (lutWe) m_lut[lutWAddr] <= int'(lutWData);
      if (m_run) begin
        m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (is_halt(mem[m_pc])) begin
          m_run <= 1'b0; m_done <= 1'b1;
        end else begin
          m_pc <= next_pc(m_pc);
        end
      end else if (start) begin
        m_run <= 1'b1; m_done <= 1'b0; m_pc <= 0; m_cnt <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pc", int'(pc), m_pc);
      chk("valid", int'(valid), int'(m_run));
      chk("done", int'(done), int'(m_done));
      chk("instr", int'(instr), m_run ? int'(mem[m_pc]) : 0);
      chk("cycleCount", int'(cycleCount), m_cnt);
    end
  end

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic lut_wr(input int a, input int d);
    lutWAddr = 4'(a); lutWData = 10'(d); lutWe = 1'b1;
    @(negedge clk);
    lutWe = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (!done && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done", int'(done), 1);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (check) begin
      chk("rst_async_pc", int'(pc), 0);
      chk("rst_async_valid", int'(valid), 0);
      chk("rst_async_instr", int'(instr), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8:0] w;
    rst_n = 1'b0; start = 1'b0; condFlag = 1'b0; lutWe = 1'b0;
    lutWAddr = '0; lutWData = '0;
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = 9'h000; br_mem[a] = 1'b0; jmp_mem[a] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pc", int'(pc), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_instr", int'(instr), 0);
    chk("reset_cnt", int'(cycleCount), 0);
    chk_on = 1'b1;

    // Sequential run with halt at 5, then a restart with start held into RUN.
    mem[5] = 9'h1F6;
    start_run();
    for (int i = 0; i < 6; i++) begin
      chk("seq_pc", int'(pc), i);
      chk("seq_valid", int'(valid), 1);
      @(negedge clk);
    end
    chk("halt_done", int'(done), 1);
    chk("halt_valid", int'(valid), 0);
    chk("halt_pc", int'(pc), 5);
    chk("halt_cnt", int'(cycleCount), 6);
    start = 1'b1;
    @(negedge clk);
    chk("restart_pc", int'(pc), 0);
    chk("restart_cnt", int'(cycleCount), 0);
    chk("restart_done", int'(done), 0);
    @(negedge clk);
    chk("held_start_pc1", int'(pc), 1);
    @(negedge clk);
    chk("held_start_pc2", int'(pc), 2);
    start = 1'b0;
    wait_done(50);
    chk("rerun_cnt", int'(cycleCount), 6);
    mem[5] = 9'h000;

`ifndef FETCH_REL_BR_EN
    // J idx3 at 2, BR idx3 at 10, halt at 12; LUT[3]=10.
    lut_wr(3, 10);
    mem[2] = 9'h030; br_mem[2] = 1'b1; jmp_mem[2] = 1'b1;
    mem[10] = 9'h030; br_mem[10] = 1'b1;
    mem[12] = 9'h1F6;
    condFlag = 1'b0;
    start_run();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("jump_pc", int'(pc), 10);
    @(negedge clk);
    chk("br_not_taken_pc", int'(pc), 11);
    @(negedge clk);
    @(negedge clk);
    chk("br_run_cnt", int'(cycleCount), 6);
    chk("br_run_done", int'(done), 1);
    condFlag = 1'b1;
    start_run();
    repeat (3) @(negedge clk);
    chk("br_taken_pc", int'(pc), 10);
    @(negedge clk);
    chk("br_selfloop_pc", int'(pc), 10);
    do_reset(1'b1);

    // LUT cleared by reset: J idx3 now lands on 0.
    start_run();
    repeat (3) @(negedge clk);
    chk("lut_cleared_pc", int'(pc), 0);
    do_reset(1'b0);

    // Same-entry hazard: jump uses old LUT[3] while the write lands.
    lut_wr(3, 10);
    jmp_mem[10] = 1'b1;
    mem[20] = 9'h1F6;
    start_run();
    @(negedge clk);
    @(negedge clk);
    lutWAddr = 4'd3; lutWData = 10'd20; lutWe = 1'b1;
    @(negedge clk);
    lutWe = 1'b0;
    chk("hazard_old_pc", int'(pc), 10);
    @(negedge clk);
    chk("hazard_new_pc", int'(pc), 20);
    @(negedge clk);
    chk("hazard_done", int'(done), 1);
    chk("hazard_cnt", int'(cycleCount), 5);

    // Wrap: jump to 1023 then sequential step to 0.
    mem[2] = 9'h010;
    lut_wr(1, 1023);
    start_run();
    repeat (3) @(negedge clk);
    chk("wrap_top_pc", int'(pc), 1023);
    @(negedge clk);
    chk("wrap_zero_pc", int'(pc), 0);
    do_reset(1'b0);
`else
    // Relative: LUT[1] = -2, BR taken at 7 lands on 5.
    lut_wr(1, 10'h3FE);
    mem[7] = 9'h010; br_mem[7] = 1'b1; condFlag = 1'b1;
    start_run();
    repeat (8) @(negedge clk);
    chk("rel_br_pc", int'(pc), 5);
    do_reset(1'b0);
`endif

    // Saturation of the 4-bit counter on a 31-cycle run.
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = 9'h000; br_mem[a] = 1'b0; jmp_mem[a] = 1'b0;
    end
    mem[30] = 9'h1F6;
    start_run();
    wait_done(100);
    chk("sat_cnt", int'(cycleCount), 15);
    chk("sat_pc", int'(pc), 30);

    // Randomized programs, LUT writes, starts and occasional resets.
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        w = 9'($urandom);
        if (is_halt(w) && ($urandom % 3 != 0)) w[8] = 1'b0;
        mem[a] = w;
        br_mem[a] = ($urandom % 4 == 0);
        jmp_mem[a] = 1'($urandom);
      end
      for (int c = 0; c < 400; c++) begin
        start = ($urandom % 10 == 0);
        condFlag = 1'($urandom);
        lutWe = ($urandom % 3 == 0);
        lutWAddr = 4'($urandom);
        lutWData = 10'($urandom);
        if ($urandom % 300 == 0) begin
          #2 rst_n = 1'b0;
          #1 chk("rnd_rst_pc", int'(pc), 0);
          chk("rnd_rst_valid", int'(valid), 0);
          rst_n = 1'b1;
        end
        @(negedge clk);
      end
    end
    start = 1'b0; lutWe = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
